spike_aer_encoder: RTL

Downstream neighbour of the LIF population stage. Consumes the packed spike-word stream (PACK_WIDTH bits per word, neuron order, one timestep per run). Converts every set bit into a single address-event (AER) carrying the absolute neuron index. Closes each timestep with an end-of-timestep marker event, so the router and synapse stages can sequence timesteps without a side channel.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/lowest_set_bit.sv | 21 ++
 rtl/spike_aer_encoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types for the spiking pipeline: encoder states, AER event layout and sizing helper.
package snn_pkg;

    localparam int AER_ADDRW = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_EOT  = 2'd3
    } enc_state_t;

    typedef struct packed {
        logic                 eot;
        logic [AER_ADDRW-1:0] addr;
    } aer_evt_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of vec, plus a found flag.
module lowest_set_bit #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan from the top so the lowest set bit is the one left standing.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            idx   = vec[i] ? IW'(i) : idx;
            found = found | vec[i];
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Packed spike words -> one AER event per set bit, closed by an end-of-timestep marker.
// Optional macro SPIKE_COUNT_EN builds the per-timestep spike counter behind o_spike_count.
module spike_aer_encoder
    import snn_pkg::*;
#(
    parameter int N          = 4096,
    parameter int ADDRW      = 12,
    parameter int PACK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_busy,
    input  logic                  i_spike_valid,
    input  logic [PACK_WIDTH-1:0] i_spike_data,
    output logic                  o_spike_ready,
    output logic                  o_evt_valid,
    output logic [ADDRW-1:0]      o_evt_addr,
    output logic                  o_evt_eot,
    input  logic                  i_evt_ready,
    output logic [ADDRW:0]        o_spike_count
);

    localparam int NWORDS = ceil_div(N, PACK_WIDTH);
    localparam int WIW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int IW     = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
    localparam int AW1    = ADDRW + 1;

    enc_state_t            state_r;
    logic [WIW-1:0]        word_idx_r;
    logic [ADDRW-1:0]      word_base_r;
    logic [PACK_WIDTH-1:0] mask_r;
    logic                  last_r;
    logic                  evt_valid_r;
    logic                  evt_eot_r;
    logic [ADDRW-1:0]      evt_addr_r;

    logic [PACK_WIDTH-1:0] keep_s;
    logic [PACK_WIDTH-1:0] enc_in_s;
    logic [PACK_WIDTH-1:0] rest_s;
    logic [IW-1:0]         lsb_idx_s;
    logic                  lsb_found_s;
    logic                  last_word_s;
    logic [ADDRW-1:0]      lsb_addr_s;

    // Bits of the current word that map to a real neuron (trims the partial last word).
    always_comb begin
        keep_s = '0;
        for (int b = 0; b < PACK_WIDTH; b++) begin
            keep_s[b] = (({1'b0, word_base_r} + AW1'(b)) < AW1'(N));
        end
    end

    // One encoder serves both the incoming word and the remaining mask; mask_r holds
    // only the bits not yet presented, so the presented event is already cleared.
    assign enc_in_s    = (state_r == S_SCAN) ? mask_r : (i_spike_data & keep_s);
    assign rest_s      = enc_in_s & ~({{(PACK_WIDTH-1){1'b0}}, 1'b1} << lsb_idx_s);
    assign lsb_addr_s  = word_base_r + ADDRW'(lsb_idx_s);
    assign last_word_s = (word_idx_r == WIW'(NWORDS - 1));

    lowest_set_bit #(
        .W  (PACK_WIDTH),
        .IW (IW)
    ) u_lsb (
        .vec   (enc_in_s),
        .idx   (lsb_idx_s),
        .found (lsb_found_s)
    );

    // Encoder FSM with registered event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            word_idx_r  <= '0;
            word_base_r <= '0;
            mask_r      <= '0;
            last_r      <= 1'b0;
            evt_valid_r <= 1'b0;
            evt_eot_r   <= 1'b0;
            evt_addr_r  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        word_idx_r  <= '0;
                        word_base_r <= '0;
                        state_r     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (i_spike_valid) begin
                        word_idx_r <= word_idx_r + WIW'(1);
                        last_r     <= last_word_s;
                        if (lsb_found_s) begin
                            evt_valid_r <= 1'b1;
                            evt_eot_r   <= 1'b0;
                            evt_addr_r  <= lsb_addr_s;
                            mask_r      <= rest_s;
                            state_r     <= S_SCAN;
                        end else if (last_word_s) begin
                            evt_valid_r <= 1'b1;
                            evt_eot_r   <= 1'b1;
                            evt_addr_r  <= '0;
                            state_r     <= S_EOT;
                        end else begin
                            word_base_r <= word_base_r + ADDRW'(PACK_WIDTH);
                        end
                    end
                end
                S_SCAN: begin
                    if (i_evt_ready) begin
                        if (lsb_found_s) begin
                            evt_addr_r <= lsb_addr_s;
                            mask_r     <= rest_s;
                        end else if (last_r) begin
                            evt_eot_r  <= 1'b1;
                            evt_addr_r <= '0;
                            state_r    <= S_EOT;
                        end else begin
                            evt_valid_r <= 1'b0;
                            word_base_r <= word_base_r + ADDRW'(PACK_WIDTH);
                            state_r     <= S_LOAD;
                        end
                    end
                end
                S_EOT: begin
                    if (i_evt_ready) begin
                        evt_valid_r <= 1'b0;
                        evt_eot_r   <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    evt_valid_r <= 1'b0;
                    evt_eot_r   <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (state_r != S_IDLE);
    assign o_spike_ready = (state_r == S_LOAD);
    assign o_evt_valid   = evt_valid_r;
    assign o_evt_eot     = evt_eot_r;
    assign o_evt_addr    = evt_addr_r;

`ifdef SPIKE_COUNT_EN
    logic [ADDRW:0] cnt_r;
    logic [ADDRW:0] spike_count_r;

    // Running spike count for the open timestep, published on the marker handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= '0;
            spike_count_r <= '0;
        end else begin
            if ((state_r == S_IDLE) && i_start) begin
                cnt_r <= '0;
            end else if ((state_r == S_SCAN) && i_evt_ready) begin
                cnt_r <= cnt_r + AW1'(1);
            end
            if ((state_r == S_EOT) && i_evt_ready) begin
                spike_count_r <= cnt_r;
            end
        end
    end

    assign o_spike_count = spike_count_r;
`else
    assign o_spike_count = '0;
`endif

endmodule
